// File: rtl/w452_pkg.sv
// rtl/w452_pkg.sv - shared types and constants for the w452 prefetch queue
package w452_pkg;

    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef logic [31:1] hw_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } pf_state_e;

    typedef struct packed {
        hw_addr_t            pc;
        logic [HALF_W-1:0]   instr;
    } pf_entry_t;

    // The first halfword of the following aligned word; wraps silently at 2^31.
    function automatic hw_addr_t next_word_base(input hw_addr_t a);
        return {a[31:2] + 30'd1, 1'b0};
    endfunction

endpackage

// File: rtl/w452_prefetch_fifo.sv
// rtl/w452_prefetch_fifo.sv - sync FIFO of {pc, instr} with 0/1/2-entry push and flush
module w452_prefetch_fifo
    import w452_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic [1:0]               push_cnt,
    input  pf_entry_t                push_data0,
    input  pf_entry_t                push_data1,
    input  logic                     pop,
    output pf_entry_t                head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pf_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     rd_ptr_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [CW-1:0]     count_q;

    // Flush empties the queue but leaves storage alone; only the pointers matter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_cnt != 2'd0) begin
                mem_q[wr_ptr_q] <= push_data0;
            end
            if (push_cnt == 2'd2) begin
                mem_q[wr_ptr_q + AW'(1)] <= push_data1;
            end
            wr_ptr_q <= wr_ptr_q + AW'(push_cnt);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_cnt) - CW'(pop);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/w452_prefetch.sv
// rtl/w452_prefetch.sv - instruction prefetch queue: fetch FSM, fetch pointer and memory handshake
module w452_prefetch
    import w452_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                redirect,
    input  logic [30:0]         redirect_pc,
    output logic                instr_valid,
    output logic [HALF_W-1:0]   instr,
    output logic [30:0]         instr_pc,
    input  logic                instr_ready,
    output logic                mem_req,
    output logic [29:0]         mem_addr,
    input  logic                mem_ack,
    input  logic [WORD_W-1:0]   mem_data
);

    localparam int CW = $clog2(DEPTH) + 1;

    pf_state_e      state_q, state_d;
    hw_addr_t       fpc_q, fpc_d;
    logic           mem_req_q;
    logic [29:0]    mem_addr_q;

    logic [1:0]     push_cnt;
    pf_entry_t      push_data0;
    pf_entry_t      push_data1;
    pf_entry_t      head;
    logic [CW-1:0]  count;
    logic           pop_fire;
    logic [CW-1:0]  free_w;
    logic           free_ok;

    assign instr_valid = (count != '0);
    assign pop_fire    = instr_valid && instr_ready && !redirect;
    // A same-cycle pop counts as space so a drained queue refetches one cycle sooner.
    assign free_w      = CW'(DEPTH) - count + CW'(pop_fire);
    assign free_ok     = (free_w >= CW'(2));

    always_comb begin
        state_d          = state_q;
        fpc_d            = fpc_q;
        push_cnt         = 2'd0;
        push_data0.pc    = fpc_q;
        push_data0.instr = fpc_q[1] ? mem_data[31:16] : mem_data[15:0];
        push_data1.pc    = fpc_q + 31'd1;
        push_data1.instr = mem_data[31:16];
        case (state_q)
            IDLE: begin
                // Redirect issues the request immediately; the flushed queue always has room.
                if (redirect) begin
                    fpc_d   = redirect_pc;
                    state_d = REQ;
                end else if (free_ok) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    fpc_d   = redirect_pc;
                    state_d = mem_ack ? IDLE : DISCARD;
                end else if (mem_ack) begin
                    push_cnt = fpc_q[1] ? 2'd1 : 2'd2;
                    fpc_d    = next_word_base(fpc_q);
                    state_d  = IDLE;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    fpc_d = redirect_pc;
                end
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            fpc_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            fpc_q     <= fpc_d;
            mem_req_q <= (state_d != IDLE);
            // The outstanding address must stay put while the stale request drains.
            if (state_d != DISCARD) begin
                mem_addr_q <= fpc_d[31:2];
            end
        end
    end

    w452_prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (redirect),
        .push_cnt   (push_cnt),
        .push_data0 (push_data0),
        .push_data1 (push_data1),
        .pop        (pop_fire),
        .head       (head),
        .count      (count)
    );

    assign instr    = head.instr;
    assign instr_pc = head.pc;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_w452_prefetch.sv
// tb/tb_w452_prefetch.sv - scoreboard bench for the w452 prefetch queue
module tb_w452_prefetch;

    logic        clk;
    logic        reset_n;
    logic        redirect;
    logic [30:0] redirect_pc;
    logic        instr_valid;
    logic [15:0] instr;
    logic [30:0] instr_pc;
    logic        instr_ready;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0] instr;
        logic [30:0] pc;
    } exp_t;

    exp_t exp_q[$];

    w452_prefetch #(.DEPTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pop(input logic [15:0] i, input logic [30:0] pc);
        exp_t e;
        e.instr = i;
        e.pc    = pc;
        exp_q.push_back(e);
    endtask

    // Monitor: every real pop is compared against the next expected entry.
    always @(negedge clk) begin
        if (reset_n && instr_valid && instr_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pop: got instr 0x%0h pc 0x%0h, expected no pop", instr, instr_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_checks++;
                if (instr === e.instr && instr_pc === e.pc) begin
                    n_pass++;
                end else begin
                    $display("FAIL pop: got instr 0x%0h pc 0x%0h, expected instr 0x%0h pc 0x%0h",
                             instr, instr_pc, e.instr, e.pc);
                end
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        mem_ack     = 1'b0;
        mem_data    = '0;
        tick();
        tick();
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_instr", 32'(instr), 32'h0);
        check("rst_instr_pc", 32'(instr_pc), 32'h0);

        // Aligned redirect
        reset_n     = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 31'h80;
        tick();
        redirect = 1'b0;
        check("redir_req", 32'(mem_req), 32'h1);
        check("redir_addr", 32'(mem_addr), 32'h40);
        mem_ack  = 1'b1;
        mem_data = 32'hBBBBAAAA;
        expect_pop(16'hAAAA, 31'h80);
        expect_pop(16'hBBBB, 31'h81);
        tick();
        mem_ack = 1'b0;
        check("aligned_valid_t2", 32'(instr_valid), 32'h1);
        check("req_low_after_ack", 32'(mem_req), 32'h0);
        check("aligned_next_addr", 32'(mem_addr), 32'h41);
        instr_ready = 1'b1;
        tick();
        tick();
        instr_ready = 1'b0;
        check("refetch_req", 32'(mem_req), 32'h1);
        check("refetch_addr", 32'(mem_addr), 32'h41);

        // Redirect while a request is outstanding
        redirect    = 1'b1;
        redirect_pc = 31'h200;
        tick();
        redirect = 1'b0;
        check("discard_req_held", 32'(mem_req), 32'h1);
        check("discard_addr_held", 32'(mem_addr), 32'h41);
        mem_ack  = 1'b1;
        mem_data = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        check("discard_no_push", 32'(instr_valid), 32'h0);
        check("discard_req_low", 32'(mem_req), 32'h0);
        tick();
        check("post_discard_req", 32'(mem_req), 32'h1);
        check("post_discard_addr", 32'(mem_addr), 32'h100);

        // Fill two entries, then redirect + pop + ack together
        mem_ack  = 1'b1;
        mem_data = 32'h22221111;
        tick();
        mem_ack = 1'b0;
        check("head_instr", 32'(instr), 32'h1111);
        check("head_pc", 32'(instr_pc), 32'h200);
        tick();
        check("second_req_addr", 32'(mem_addr), 32'h101);
        redirect    = 1'b1;
        redirect_pc = 31'h81;
        instr_ready = 1'b1;
        mem_ack     = 1'b1;
        mem_data    = 32'h66665555;
        tick();
        redirect    = 1'b0;
        instr_ready = 1'b0;
        mem_ack     = 1'b0;
        check("simul_empty", 32'(instr_valid), 32'h0);
        check("simul_idle", 32'(mem_req), 32'h0);

        // Odd redirect
        tick();
        check("odd_req", 32'(mem_req), 32'h1);
        check("odd_addr", 32'(mem_addr), 32'h40);
        mem_ack  = 1'b1;
        mem_data = 32'hBBBBAAAA;
        expect_pop(16'hBBBB, 31'h81);
        tick();
        mem_ack = 1'b0;
        check("odd_valid", 32'(instr_valid), 32'h1);
        check("odd_next_addr", 32'(mem_addr), 32'h41);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("odd_single_entry", 32'(instr_valid), 32'h0);

        // Full queue
        mem_ack  = 1'b1;
        mem_data = 32'h44443333;
        expect_pop(16'h3333, 31'h82);
        expect_pop(16'h4444, 31'h83);
        tick();
        mem_ack = 1'b0;
        check("fill1_req_low", 32'(mem_req), 32'h0);
        tick();
        check("fill2_req", 32'(mem_req), 32'h1);
        check("fill2_addr", 32'(mem_addr), 32'h42);
        mem_ack  = 1'b1;
        mem_data = 32'h66665555;
        expect_pop(16'h5555, 31'h84);
        expect_pop(16'h6666, 31'h85);
        tick();
        mem_ack = 1'b0;
        tick();
        check("full_req_low", 32'(mem_req), 32'h0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("one_pop_req_low", 32'(mem_req), 32'h0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("two_pop_req", 32'(mem_req), 32'h1);
        check("two_pop_addr", 32'(mem_addr), 32'h43);

        // Reset mid-request
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_mem_req", 32'(mem_req), 32'h0);
        check("midrst_mem_addr", 32'(mem_addr), 32'h0);
        check("midrst_valid", 32'(instr_valid), 32'h0);
        check("midrst_instr", 32'(instr), 32'h0);
        check("midrst_pc", 32'(instr_pc), 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("post_rst_req_low", 32'(mem_req), 32'h0);
        tick();
        check("post_rst_req", 32'(mem_req), 32'h1);
        check("post_rst_addr", 32'(mem_addr), 32'h0);
        mem_ack  = 1'b1;
        mem_data = 32'h87654321;
        expect_pop(16'h4321, 31'h0);
        expect_pop(16'h8765, 31'h1);
        tick();
        mem_ack     = 1'b0;
        instr_ready = 1'b1;
        tick();
        tick();
        instr_ready = 1'b0;
        check("all_pops_seen", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/w452_prefetch.md
# w452_prefetch

Instruction prefetch queue sitting directly upstream of the w452 core's 16-bit instruction-fetch port. It fetches aligned 32-bit words from instruction memory over a req/ack handshake and splits each into two 16-bit instructions. The instructions are buffered in a small FIFO tagged with their halfword PC. The core pops one instruction per handshake and redirects the stream on any taken branch or jump.

## Interface
- `DEPTH`, default 4: queue entries, each a 16-bit instruction plus a 31-bit PC; power of two, ≥ 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `redirect`  in  1  flush the queue and restart fetch at `redirect_pc`.
- `redirect_pc`  in  31  new halfword address, bits [31:1].
- `instr_valid`  out  1  head entry is valid.
- `instr`  out  16  head instruction.
- `instr_pc`  out  31  halfword address of the head instruction.
- `instr_ready`  in  1  core accepts the head; a pop occurs when `instr_valid && instr_ready`.
- `mem_req`  out  1  read request to instruction memory.
- `mem_addr`  out  30  word address, bits [31:2].
- `mem_ack`  in  1  single-cycle acknowledge; `mem_data` is valid in the same cycle.
- `mem_data`  in  32  `[15:0]` holds the halfword at `{mem_addr,0}`; `[31:16]` holds the halfword at `{mem_addr,1}`.

## Operation
- Fetch pointer `fpc[31:1]` resets to 0. `mem_addr` is `fpc[31:2]`.
- States:
  - IDLE: if free entries ≥ 2 and not `redirect`, assert `mem_req` and go to REQ.
  - REQ: hold `mem_req` and `mem_addr` stable until `mem_ack`.
  - DISCARD: a request is outstanding but has been invalidated by a redirect.
- On `mem_ack` in REQ:
  - If `fpc[1]==0`, push `mem_data[15:0]` tagged `fpc`, then `mem_data[31:16]` tagged `fpc+1`.
  - If `fpc[1]==1`, push only `mem_data[31:16]` tagged `fpc`.
  - `fpc` advances to the next word base, `{fpc[31:2]+1, 0}`.
  - Drop `mem_req` and go to IDLE.
- The free-entry check (≥ 2) is made at request issue. Pops can only add space, so a push never overflows.
- `redirect` (highest priority):
  - Empty the queue and load `fpc <= redirect_pc`.
  - Any pop in the same cycle is void.
  - From REQ, go to DISCARD. `mem_req` stays high until `mem_ack`, `mem_addr` is unchanged, and the acked data is dropped. Then go to IDLE.
  - A redirect that coincides with `mem_ack` drops that data and goes to IDLE.
  - Redirects in DISCARD only reload `fpc`.
- Pointers wrap modulo `DEPTH`. The count ranges from 0 to `DEPTH` and uses `$clog2(DEPTH)+1` bits.
- `fpc` increments wrap silently at 2^31.
- Reset values: `mem_req`=0, `mem_addr`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0; queue empty; state IDLE.
- Reset asserted mid-request abandons the request. Memory must tolerate an unacked request being withdrawn.

## Timing
- All outputs are registered, or driven from registered FIFO storage.
- `redirect` at cycle t gives `mem_req`=1 at t+1.
- With a zero-wait memory (ack at t+1), `instr_valid`=1 at t+2.
- After an ack cycle, `mem_req` is low for at least one cycle. Peak throughput is two halfwords per two cycles.
- A push and a pop in the same cycle are both honoured. The count changes by pushes − pops.
- A pushed entry is visible at the head the cycle after the push. There is no bypass from `mem_data` to `instr`.

## Structure
- Shared package `w452_pkg`:
  - state enum `{IDLE, REQ, DISCARD}`;
  - `HALF_W=16`, `WORD_W=32`;
  - halfword-address type `logic [31:1]`.
- Sub-module `w452_prefetch_fifo`: sync FIFO of `{pc, instr}` entries with a 0/1/2-entry push port, a single pop port and synchronous flush.
- The top level holds the fetch FSM, `fpc` and the memory handshake.

## Test plan
1. Aligned redirect:
   - Stimulus: reset, then `redirect` with `redirect_pc`=0x80; memory acks word 0x40 with 0xBBBBAAAA.
   - Response: pops give `instr`=0xAAAA, `instr_pc`=0x80, then `instr`=0xBBBB, `instr_pc`=0x81.
   - The next `mem_addr` is 0x41.
2. Odd redirect:
   - Stimulus: `redirect_pc`=0x81 (byte 0x102); ack with 0xBBBBAAAA.
   - Response: a single entry, 0xBBBB at pc 0x81; the next request is word 0x41.
3. Full queue (`DEPTH`=4):
   - With `instr_ready`=0, two acked requests fill the queue and `mem_req` then stays 0.
   - One pop leaves `mem_req` at 0; a second pop gives `mem_req`=1 the next cycle.
4. Redirect while outstanding:
   - Stimulus: request word 0x40 pending, `redirect_pc`=0x200, then ack with 0xDEADBEEF.
   - Response: nothing is pushed, and the next `mem_req` has `mem_addr`=0x100.
5. Simultaneous redirect, pop and `mem_ack`:
   - Response: the queue is empty next cycle, `instr_valid`=0, the ack data is dropped, and the state goes to IDLE.
6. Reset mid-request:
   - Stimulus: `reset_n` is low while in REQ.
   - Response: all outputs go to 0 immediately. After release, `mem_req` stays 0 until a redirect, or until the free-entry check passes with fetch resuming at `fpc`=0.
